fpu_op_dispatch: RTL and testbench

Single-precision FPU issue stage sitting between the core's execute stage and the FPU functional units: sign-injection, min/max, add/sub, mul, div and sqrt.
- Accepts one R-type FP request over a valid/ready handshake and decodes funct7/funct3.
- Pulses the selected unit's start with stable operands, waits for that unit's done, captures its result.
- Returns the result over a valid/ready response handshake, with illegal-instruction and timeout flags.
- One request in flight at a time.

---
 rtl/fpu_op_dispatch_pkg.sv | 18 +
 rtl/fpu_op_dispatch_if.sv | 32 +++
 rtl/fpu_op_decode.sv | 29 ++
 rtl/fpu_op_dispatch.sv | 109 ++++++++++
 tb/tb_fpu_op_dispatch.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/fpu_op_dispatch_pkg.sv
// fpu_op_dispatch_pkg: unit indices, funct7 encodings and FSM states shared by the FP issue stage
package fpu_op_dispatch_pkg;
  localparam int NUM_UNITS   = 6;
  localparam int UNIT_SGNJ   = 0;
  localparam int UNIT_MINMAX = 1;
  localparam int UNIT_ADDSUB = 2;
  localparam int UNIT_MUL    = 3;
  localparam int UNIT_DIV    = 4;
  localparam int UNIT_SQRT   = 5;
  localparam logic [6:0] F7_SGNJ   = 7'b0010000;
  localparam logic [6:0] F7_MINMAX = 7'b0010100;
  localparam logic [6:0] F7_ADD    = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0000100;
  localparam logic [6:0] F7_MUL    = 7'b0001000;
  localparam logic [6:0] F7_DIV    = 7'b0001100;
  localparam logic [6:0] F7_SQRT   = 7'b0101100;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/fpu_op_dispatch_if.sv
// fpu_op_dispatch_if: request, functional-unit and response signals of the FP issue stage
interface fpu_op_dispatch_if;
  logic         req_valid;
  logic         req_ready;
  logic [6:0]   req_funct7;
  logic [2:0]   req_funct3;
  logic [31:0]  req_rs1;
  logic [31:0]  req_rs2;
  logic [4:0]   req_rd;
  logic [5:0]   unit_start;
  logic [31:0]  unit_operand_a;
  logic [31:0]  unit_operand_b;
  logic [2:0]   unit_func3;
  logic [5:0]   unit_done;
  logic [191:0] unit_result;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_result;
  logic [4:0]   resp_rd;
  logic         resp_illegal;
  logic         resp_timeout;
  modport master (
    output req_valid, req_funct7, req_funct3, req_rs1, req_rs2, req_rd, unit_done, unit_result, resp_ready,
    input  req_ready, unit_start, unit_operand_a, unit_operand_b, unit_func3,
           resp_valid, resp_result, resp_rd, resp_illegal, resp_timeout
  );
  modport slave (
    input  req_valid, req_funct7, req_funct3, req_rs1, req_rs2, req_rd, unit_done, unit_result, resp_ready,
    output req_ready, unit_start, unit_operand_a, unit_operand_b, unit_func3,
           resp_valid, resp_result, resp_rd, resp_illegal, resp_timeout
  );
endinterface

// File: rtl/fpu_op_decode.sv
// fpu_op_decode: maps funct7/funct3/rs2 to a one-hot unit select, unit sub-opcode and illegal flag
module fpu_op_decode
  import fpu_op_dispatch_pkg::*;
(
  input  logic [6:0]           funct7_i,
  input  logic [2:0]           funct3_i,
  input  logic [31:0]          rs2_i,
  output logic [NUM_UNITS-1:0] sel_o,
  output logic [2:0]           func3_o,
  output logic                 illegal_o
);
  // decode table; an illegal encoding never selects a unit
  always_comb begin
    sel_o     = '0;
    func3_o   = funct3_i;
    illegal_o = 1'b0;
    case (funct7_i)
      F7_SGNJ:   begin sel_o[UNIT_SGNJ] = 1'b1; illegal_o = funct3_i > 3'd2; end
      F7_MINMAX: begin sel_o[UNIT_MINMAX] = 1'b1; illegal_o = funct3_i > 3'd1; end
      F7_ADD:    begin sel_o[UNIT_ADDSUB] = 1'b1; func3_o = 3'b000; end
      F7_SUB:    begin sel_o[UNIT_ADDSUB] = 1'b1; func3_o = 3'b001; end
      F7_MUL:    sel_o[UNIT_MUL] = 1'b1;
      F7_DIV:    sel_o[UNIT_DIV] = 1'b1;
      F7_SQRT:   begin sel_o[UNIT_SQRT] = 1'b1; illegal_o = |rs2_i; end
      default:   illegal_o = 1'b1;
    endcase
    if (illegal_o) sel_o = '0;
  end
endmodule

// File: rtl/fpu_op_dispatch.sv
// fpu_op_dispatch: issues one FP request at a time to its functional unit and returns the result
module fpu_op_dispatch
  import fpu_op_dispatch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input logic              clk,
  input logic              rst,
  fpu_op_dispatch_if.slave bus
);
  state_t               state_q, state_d;
  logic [NUM_UNITS-1:0] sel_q, dec_sel;
  logic [31:0]          a_q, b_q, res_q, res_d, hit_res;
  logic [2:0]           f3_q, dec_f3;
  logic [4:0]           rd_q;
  logic                 ill_q, ill_d, to_q, to_d, dec_ill, acc, hit;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  fpu_op_decode u_dec (
    .funct7_i (bus.req_funct7),
    .funct3_i (bus.req_funct3),
    .rs2_i    (bus.req_rs2),
    .sel_o    (dec_sel),
    .func3_o  (dec_f3),
    .illegal_o(dec_ill)
  );
  assign acc                = (state_q == IDLE) & bus.req_valid;
  assign hit                = |(bus.unit_done & sel_q);
  assign bus.req_ready      = (state_q == IDLE) & ~rst;
  assign bus.unit_start     = (state_q == ISSUE) ? sel_q : '0;
  assign bus.unit_operand_a = a_q;
  assign bus.unit_operand_b = b_q;
  assign bus.unit_func3     = f3_q;
  assign bus.resp_valid     = state_q == RESP;
  assign bus.resp_result    = res_q;
  assign bus.resp_rd        = rd_q;
  assign bus.resp_illegal   = ill_q;
  assign bus.resp_timeout   = to_q;
  // result of the selected unit only; other units' buses are ignored
  always_comb begin
    hit_res = '0;
    for (int i = 0; i < NUM_UNITS; i++) hit_res = hit_res | (sel_q[i] ? bus.unit_result[32*i +: 32] : 32'h0);
  end
  // next state: done is only honoured in ISSUE/WAIT and beats a simultaneous timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ill_d   = ill_q;
    to_d    = to_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d = dec_ill ? RESP : ISSUE;
        res_d   = '0;
        ill_d   = dec_ill;
        to_d    = 1'b0;
      end
      ISSUE: begin
        state_d = hit ? RESP : WAIT;
        res_d   = hit ? hit_res : res_q;
        cnt_d   = CNT_W'(1);
      end
      WAIT: begin
        if (hit) begin
          state_d = RESP;
          res_d   = hit_res;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d = RESP;
          res_d   = '0;
          to_d    = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      RESP: if (bus.resp_ready) begin
        state_d = IDLE;
        ill_d   = 1'b0;
        to_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, response registers, and request capture at accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      if (acc) begin
        sel_q <= dec_sel;
        a_q   <= bus.req_rs1;
        b_q   <= bus.req_rs2;
        f3_q  <= dec_f3;
        rd_q  <= bus.req_rd;
      end
    end
  end
endmodule

// File: tb/tb_fpu_op_dispatch.sv
// tb_fpu_op_dispatch: directed requests with a scoreboard checked by a response monitor
module tb_fpu_op_dispatch;
  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
    logic        to;
    logic [5:0]  start;
    int          lat;
  } exp_t;
  logic clk = 0, rst = 1;
  int total = 0, bad = 0, cyc = 0;
  exp_t q[$];
  int dly = -1, rem = -1;
  logic stray_en = 0;
  logic [5:0] psel = 0, dn = 0, stray = 0;
  logic [31:0] ures [6];
  logic [31:0] exp_a = 0, sres;
  logic [2:0] exp_f3 = 0;
  fpu_op_dispatch_if bus();
  fpu_op_dispatch #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign sres = {bus.unit_func3 == 3'd0 ? bus.unit_operand_b[31] :
                 bus.unit_func3 == 3'd1 ? ~bus.unit_operand_b[31] :
                 bus.unit_operand_a[31] ^ bus.unit_operand_b[31], bus.unit_operand_a[30:0]};
  assign bus.unit_done   = (dn & 6'b111110) | {5'b0, bus.unit_start[0]} | stray;
  assign bus.unit_result = {ures[5], ures[4], ures[3], ures[2], ures[1], sres};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // multi-cycle unit model: done arrives dly cycles after the start cycle
  initial forever begin
    @(negedge clk);
    dn = '0;
    if (rst) rem = -1;
    else begin
      if (|bus.unit_start[5:1]) begin
        psel = bus.unit_start;
        rem  = dly;
      end else if (rem >= 0) rem--;
      if (rem == 0) begin
        dn = psel;
        chk("unit_operand_a", bus.unit_operand_a, exp_a);
        chk("unit_func3", {29'b0, bus.unit_func3}, {29'b0, exp_f3});
      end else if (stray_en && rem > 0 && rem % 2 == 1) dn[2] = 1'b1;
    end
  end

  // response monitor
  initial begin
    int acc = 0, first = 0, scnt = 0;
    bit seen = 0;
    logic [5:0] sst = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        seen = 0; sst = 0; scnt = 0;
      end else begin
        if (bus.req_valid && bus.req_ready) begin
          acc = cyc; seen = 0; sst = 0; scnt = 0;
        end
        if (|bus.unit_start) begin
          sst = sst | bus.unit_start;
          scnt++;
        end
        if (bus.resp_valid) begin
          if (q.size() == 0) chk("unexpected_resp", {31'b0, bus.resp_valid}, 32'd0);
          else begin
            if (!seen) begin
              seen = 1;
              first = cyc;
              chk("latency", 32'(first - acc), 32'(q[0].lat));
              chk("start_bits", {26'b0, sst}, {26'b0, q[0].start});
              chk("start_pulses", 32'(scnt), (q[0].start != 0) ? 32'd1 : 32'd0);
            end
            chk("resp_result", bus.resp_result, q[0].res);
            chk("resp_rd", {27'b0, bus.resp_rd}, {27'b0, q[0].rd});
            chk("resp_illegal", {31'b0, bus.resp_illegal}, {31'b0, q[0].ill});
            chk("resp_timeout", {31'b0, bus.resp_timeout}, {31'b0, q[0].to});
            if (bus.resp_ready) void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic send(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] er, input logic ei, input logic et,
                      input logic [5:0] es, input int lat);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("req_ready_wait", 32'd0, 32'd1);
    exp_a  = a;
    exp_f3 = (f7 == 7'b0000000) ? 3'd0 : (f7 == 7'b0000100) ? 3'd1 : f3;
    bus.req_funct7 = f7; bus.req_funct3 = f3; bus.req_rs1 = a; bus.req_rs2 = b; bus.req_rd = rd;
    bus.req_valid = 1;
    q.push_back('{er, rd, ei, et, es, lat});
    @(posedge clk);
    #1 bus.req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 6; i++) ures[i] = 32'hA5A50000 + i;
    bus.req_valid = 0; bus.req_funct7 = 0; bus.req_funct3 = 0; bus.req_rs1 = 0; bus.req_rs2 = 0; bus.req_rd = 0;
    bus.resp_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_unit_start", {26'b0, bus.unit_start}, 32'd0);
    #2 rst = 0;
    @(negedge clk);
    chk("post_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    stray = 6'b111111;
    repeat (3) @(negedge clk);
    stray = 0;
    send(7'b0010000, 3'b001, 32'h3F800000, 32'h00000000, 5'd5, 32'hBF800000, 0, 0, 6'b000001, 2);
    drain();
    send(7'b0010000, 3'b010, 32'hC0000000, 32'h80000000, 5'd7, 32'h40000000, 0, 0, 6'b000001, 2);
    drain();
    dly = 9; ures[4] = 32'h40000000; stray_en = 1;
    send(7'b0001100, 3'b011, 32'h40800000, 32'h40000000, 5'd9, 32'h40000000, 0, 0, 6'b010000, 11);
    drain();
    stray_en = 0;
    send(7'b1111111, 3'b000, 32'h12345678, 32'h9ABCDEF0, 5'd3, 32'h0, 1, 0, 6'b000000, 1);
    drain();
    send(7'b0101100, 3'b000, 32'h40800000, 32'h00000001, 5'd4, 32'h0, 1, 0, 6'b000000, 1);
    drain();
    send(7'b0010000, 3'b011, 32'h3F800000, 32'h3F800000, 5'd6, 32'h0, 1, 0, 6'b000000, 1);
    drain();
    dly = -1; ures[3] = 32'hDEADBEEF;
    send(7'b0001000, 3'b000, 32'h3F800000, 32'h40000000, 5'd8, 32'h0, 0, 1, 6'b001000, 66);
    drain();
    dly = 64; ures[3] = 32'h12345678;
    send(7'b0001000, 3'b010, 32'h3F800000, 32'h40000000, 5'd10, 32'h12345678, 0, 0, 6'b001000, 66);
    drain();
    dly = 2; ures[2] = 32'h11111111; bus.resp_ready = 0;
    send(7'b0000100, 3'b111, 32'h3F800000, 32'h3F800000, 5'd11, 32'h11111111, 0, 0, 6'b000100, 4);
    begin
      int n = 0;
      while (!bus.resp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    dly = 0; ures[2] = 32'h22222222; exp_a = 32'h00000001; exp_f3 = 3'd0; stray = 6'b111111;
    bus.req_funct7 = 7'b0000000; bus.req_funct3 = 3'b111; bus.req_rs1 = 32'h1; bus.req_rs2 = 32'h2; bus.req_rd = 5'd12;
    bus.req_valid = 1;
    q.push_back('{32'h22222222, 5'd12, 1'b0, 1'b0, 6'b000100, 2});
    repeat (5) begin
      @(negedge clk);
      chk("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    stray = 0; bus.resp_ready = 1;
    @(posedge clk);
    @(posedge clk);
    #1 bus.req_valid = 0;
    drain();
    dly = -1;
    send(7'b0001000, 3'b001, 32'h40400000, 32'h40A00000, 5'd13, 32'h0, 0, 0, 6'b001000, 0);
    void'(q.pop_back());
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_unit_start", {26'b0, bus.unit_start}, 32'd0);
    chk("arst_operand_a", bus.unit_operand_a, 32'd0);
    chk("arst_operand_b", bus.unit_operand_b, 32'd0);
    chk("arst_func3", {29'b0, bus.unit_func3}, 32'd0);
    chk("arst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("arst_resp_result", bus.resp_result, 32'd0);
    chk("arst_resp_rd", {27'b0, bus.resp_rd}, 32'd0);
    chk("arst_flags", {30'b0, bus.resp_illegal, bus.resp_timeout}, 32'd0);
    chk("arst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("arst_release_ready", {31'b0, bus.req_ready}, 32'd1);
    repeat (80) @(negedge clk);
    dly = 0; ures[1] = 32'h3F000000;
    send(7'b0010100, 3'b001, 32'h3F000000, 32'hBF000000, 5'd20, 32'h3F000000, 0, 0, 6'b000010, 2);
    drain();
    send(7'b0010100, 3'b010, 32'h3F000000, 32'hBF000000, 5'd21, 32'h0, 1, 0, 6'b000000, 1);
    drain();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
